// File: rtl/gpu_linebuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_linebuf_pkg
// Purpose  : Shared types and constants for the GPU pixel line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package gpu_linebuf_pkg;

   localparam int LINE_PIX    = 16;
   localparam int LINE_TAG_W  = 15;
   localparam int LINE_DATA_W = 256;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FILL  = 2'd1,
      ST_FLUSH = 2'd2
   } lb_state_e;

   // Line tag: screen row plus the 16-pixel column group.
   function automatic logic [LINE_TAG_W-1:0] line_tag(input logic [8:0] i_y,
                                                      input logic [5:0] i_xHi);
      return {i_y, i_xHi};
   endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_pixel_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pixel_line_buffer_if
// Purpose  : Line-flush bus between the pixel line buffer (master) and the
//            VRAM arbiter (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface gpu_pixel_line_buffer_if;
   import gpu_linebuf_pkg::*;

   logic                   o_flushReq;
   logic [LINE_TAG_W-1:0]  o_flushAdr;
   logic [LINE_DATA_W-1:0] o_flushData;
   logic [LINE_PIX-1:0]    o_flushMask;
   logic                   i_flushAck;

   modport master (
      output o_flushReq,
      output o_flushAdr,
      output o_flushData,
      output o_flushMask,
      input  i_flushAck
   );

   modport slave (
      input  o_flushReq,
      input  o_flushAdr,
      input  o_flushData,
      input  o_flushMask,
      output i_flushAck
   );

endinterface
`default_nettype wire

// File: rtl/gpu_linebuf_store.sv
`default_nettype none
// ============================================================================
// Module   : gpu_linebuf_store
// Purpose  : 16 x 16-bit pixel register array with per-slot write mask,
//            single-slot write and whole-line clear.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_linebuf_store
   import gpu_linebuf_pkg::*;
(
   input  wire logic                   clk,
   input  wire logic                   i_nrst,
   input  wire logic                   i_clr,
   input  wire logic                   i_we,
   input  wire logic [3:0]             i_slot,
   input  wire logic [15:0]            i_data,
   output logic      [LINE_DATA_W-1:0] o_data,
   output logic      [LINE_PIX-1:0]    o_mask
);

   logic [15:0]         r_pix [LINE_PIX];
   logic [LINE_PIX-1:0] r_mask;

   // Clear zeroes data as well so unwritten slots always flush as zero.
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         for (int i = 0; i < LINE_PIX; i++) r_pix[i] <= '0;
         r_mask <= '0;
      end else if (i_clr) begin
         for (int i = 0; i < LINE_PIX; i++) r_pix[i] <= '0;
         r_mask <= '0;
      end else if (i_we) begin
         r_pix[i_slot]  <= i_data;
         r_mask[i_slot] <= 1'b1;
      end
   end

   for (genvar g = 0; g < LINE_PIX; g++) begin : g_pack
      assign o_data[16*g +: 16] = r_pix[g];
   end

   assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/gpu_pixel_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pixel_line_buffer
// Purpose  : Collects finished pixels into a 16-pixel VRAM line, flushes the
//            line to the VRAM arbiter on line change / new line / end of
//            primitive, and stalls the pipeline until the write is acked.
// Options  : GPU_LINEBUF_MASKBIT_EN - OR i_forceMask into stored bit 15.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_pixel_line_buffer
   import gpu_linebuf_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        i_nrst,
   input  wire logic        i_validPixel,
   input  wire logic [9:0]  i_scrX,
   input  wire logic [8:0]  i_scrY,
   input  wire logic [15:0] i_texel,
   input  wire logic        i_transparent,
   input  wire logic [1:0]  i_newLine,
   input  wire logic        i_flushAll,
   input  wire logic        i_forceMask,
   output logic             o_pause,
   output logic             o_resetLineFlag,
   output logic             o_idle,
   gpu_pixel_line_buffer_if.master vram
);

   lb_state_e              r_state;
   lb_state_e              w_nextState;
   logic [LINE_TAG_W-1:0]  r_tag;
   logic                   r_flushPend;

   logic                   r_flushReq;
   logic [LINE_TAG_W-1:0]  r_flushAdr;
   logic [LINE_DATA_W-1:0] r_flushData;
   logic [LINE_PIX-1:0]    r_flushMask;

   logic [LINE_TAG_W-1:0]  w_pixTag;
   logic                   w_tagMatch;
   logic                   w_newLine;
   logic                   w_needFlush;
   logic                   w_accept;
   logic                   w_capture;
   logic                   w_clr;
   logic                   w_rlf;
   logic [15:0]            w_pixData;
   logic [LINE_DATA_W-1:0] w_storeData;
   logic [LINE_PIX-1:0]    w_storeMask;

   assign w_pixTag   = line_tag(i_scrY, i_scrX[9:4]);
   assign w_tagMatch = (w_pixTag == r_tag);
   assign w_newLine  = |i_newLine;

`ifdef GPU_LINEBUF_MASKBIT_EN
   assign w_pixData = {i_texel[15] | i_forceMask, i_texel[14:0]};
`else
   logic w_unused_forceMask;
   assign w_pixData          = i_texel;
   assign w_unused_forceMask = i_forceMask;
`endif

   gpu_linebuf_store u_store (
      .clk    (clk),
      .i_nrst (i_nrst),
      .i_clr  (w_clr),
      .i_we   (w_accept & ~i_transparent),
      .i_slot (i_scrX[3:0]),
      .i_data (w_pixData),
      .o_data (w_storeData),
      .o_mask (w_storeMask)
   );

   // State register.
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) r_state <= ST_EMPTY;
      else         r_state <= w_nextState;
   end

   // Next state, flush decision, acceptance and new-line acknowledge.
   // An end-of-primitive arriving with a matching pixel lets the pixel in
   // first; r_flushPend then forces the flush on the following cycle.
   always_comb begin
      w_nextState = r_state;
      w_needFlush = 1'b0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_clr       = 1'b0;
      w_rlf       = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            w_accept = i_validPixel;
            w_rlf    = w_newLine;
            if (i_validPixel) w_nextState = ST_FILL;
         end
         ST_FILL: begin
            w_needFlush = (i_validPixel & ~w_tagMatch) | w_newLine | r_flushPend |
                          (i_flushAll & ~(i_validPixel & w_tagMatch));
            if (w_needFlush) begin
               w_clr = 1'b1;
               if (|w_storeMask) begin
                  w_capture   = 1'b1;
                  w_nextState = ST_FLUSH;
               end else begin
                  w_rlf       = w_newLine;
                  w_nextState = ST_EMPTY;
               end
            end else begin
               w_accept = i_validPixel;
            end
         end
         ST_FLUSH: begin
            if (vram.i_flushAck) w_nextState = ST_EMPTY;
         end
         default: w_nextState = ST_EMPTY;
      endcase
   end

   // Line tag and deferred end-of-primitive flag.
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_tag       <= '0;
         r_flushPend <= 1'b0;
      end else begin
         if (w_accept)   r_tag <= w_pixTag;
         else if (w_clr) r_tag <= '0;
         r_flushPend <= w_accept & i_flushAll;
      end
   end

   // Flush request and frozen line snapshot, held until acknowledged.
   always_ff @(posedge clk or negedge i_nrst) begin
      if (!i_nrst) begin
         r_flushReq  <= 1'b0;
         r_flushAdr  <= '0;
         r_flushData <= '0;
         r_flushMask <= '0;
      end else if (w_capture) begin
         r_flushReq  <= 1'b1;
         r_flushAdr  <= r_tag;
         r_flushData <= w_storeData;
         r_flushMask <= w_storeMask;
      end else if ((r_state == ST_FLUSH) && vram.i_flushAck) begin
         r_flushReq  <= 1'b0;
      end
   end

   assign o_pause         = w_needFlush | (r_state == ST_FLUSH);
   assign o_resetLineFlag = w_rlf;
   assign o_idle          = (r_state == ST_EMPTY);

   assign vram.o_flushReq  = r_flushReq;
   assign vram.o_flushAdr  = r_flushAdr;
   assign vram.o_flushData = r_flushData;
   assign vram.o_flushMask = r_flushMask;

endmodule
`default_nettype wire
